// File: rtl/seven_segment_pkg.sv
// Shared types and default constants for the seven-segment display arbiter.
package seven_segment_pkg;

  // Controller states: nobody owns the display, or one requester owns it.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int DEF_W     = 32;
  localparam int DEF_N_REQ = 2;
  localparam int DEF_DIV_W = 16;

endpackage

// File: rtl/seven_segment_rr_pick.sv
// Combinational round-robin pick: the first requester found after 'last'
// (wrapping modulo n_req) wins. Output is one-hot, or all-zero if req is 0.
module seven_segment_rr_pick #(
  parameter int n_req = 2,
  parameter int idx_w = (n_req > 1) ? $clog2(n_req) : 1
) (
  input  logic [n_req-1:0] req,
  input  logic [idx_w-1:0] last,
  output logic [n_req-1:0] pick
);

  logic found;

  // Scan candidates in priority order last+1, last+2, ... and keep the first hit.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= n_req; k++) begin
      for (int j = 0; j < n_req; j++) begin
        if (!found && req[j] && (j == (int'(last) + k) % n_req)) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seven_segment_arbiter.sv
// Seven-segment display arbiter: a refresh prescaler drives the display
// strobe 'en', a scan counter tracks the digit position, and a two-state
// controller hands the display to one requester at a time, switching owners
// only at the end of a complete digit scan.
// Optional build macro SEVEN_SEGMENT_ARBITER_OWNER_DOT_EN lights the dot of
// the digit whose index equals the current owner.
module seven_segment_arbiter
  import seven_segment_pkg::*;
#(
  parameter int w        = DEF_W,
  parameter int n_digits = w / 4,
  parameter int n_req    = DEF_N_REQ,
  parameter int div_w    = DEF_DIV_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [div_w-1:0]          refresh_div,
  input  logic [n_req-1:0]          req,
  input  logic [n_req*w-1:0]        num_in,
  input  logic [n_req*n_digits-1:0] dots_in,
  output logic [n_req-1:0]          gnt,
  output logic                      en,
  output logic [w-1:0]              num,
  output logic [n_digits-1:0]       dots
);

  localparam int idx_w = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int sc_w  = (n_digits > 1) ? $clog2(n_digits) : 1;
  localparam logic [sc_w-1:0]  SCAN_LAST  = sc_w'(n_digits - 1);
  localparam logic [idx_w-1:0] LAST_RESET = idx_w'(n_req - 1);

  logic [div_w-1:0]    cnt_q, cnt_d;
  logic [sc_w-1:0]     scan_q, scan_d;
  state_t              state_q, state_d;
  logic [n_req-1:0]    gnt_q, gnt_d;
  logic [idx_w-1:0]    last_q, last_d;
  logic [w-1:0]        num_q, num_d;
  logic [n_digits-1:0] dots_q, dots_d;

  logic [n_req-1:0]    pick;
  logic [idx_w-1:0]    pick_idx;
  logic                scan_end;

  // The strobe is gated by rst_n so it drops the moment reset asserts,
  // even when refresh_div is 0 and the count matches.
  assign en       = rst_n & (cnt_q == refresh_div);
  assign scan_end = en && (scan_q == SCAN_LAST);

  assign gnt  = gnt_q;
  assign num  = num_q;
  assign dots = dots_q;

  seven_segment_rr_pick #(
    .n_req (n_req),
    .idx_w (idx_w)
  ) u_rr_pick (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

  // Encode the one-hot pick into the owner index remembered for round-robin.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < n_req; i++) begin
      if (pick[i]) pick_idx = idx_w'(i);
    end
  end

  // Prescaler: count up to refresh_div; a count at or beyond it wraps, so a
  // lowered terminal count takes effect without running through the old range.
  always_comb begin
    cnt_d = (cnt_q >= refresh_div) ? '0 : cnt_q + div_w'(1);
  end

  // Controller next state: grant on leaving IDLE, re-arbitrate only at scan end.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    scan_d  = en ? ((scan_q == SCAN_LAST) ? '0 : scan_q + sc_w'(1)) : scan_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          gnt_d   = pick;
          last_d  = pick_idx;
          scan_d  = '0;
        end
      end
      OWN: begin
        if (scan_end) begin
          if (|req) begin
            // With only the owner requesting, the pick wraps back to it.
            gnt_d  = pick;
            last_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Display data: the current owner's slice, blanked in the same cycle the
  // controller falls back to IDLE so num/dots never outlive the grant.
  always_comb begin
    num_d  = '0;
    dots_d = '0;
    if (state_q == OWN && state_d == OWN) begin
      for (int i = 0; i < n_req; i++) begin
        if (i == int'(last_q)) begin
          num_d  = num_in[i*w +: w];
          dots_d = dots_in[i*n_digits +: n_digits];
        end
      end
`ifdef SEVEN_SEGMENT_ARBITER_OWNER_DOT_EN
      for (int j = 0; j < n_digits; j++) begin
        if (j == int'(last_q)) dots_d[j] = 1'b1;
      end
`endif
    end
  end

  // State registers, all cleared asynchronously so reset abandons any scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      scan_q  <= '0;
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RESET;
      num_q   <= '0;
      dots_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      num_q   <= num_d;
      dots_q  <= dots_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Self-checking bench for seven_segment_arbiter: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_seven_segment_arbiter;

  localparam int W  = 32;
  localparam int ND = 8;
  localparam int NR = 2;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    refresh_div;
  logic [NR-1:0]    req;
  logic [NR*W-1:0]  num_in;
  logic [NR*ND-1:0] dots_in;
  logic [NR-1:0]    gnt;
  logic             en;
  logic [W-1:0]     num;
  logic [ND-1:0]    dots;

  int errors = 0;
  int checks = 0;

  seven_segment_arbiter #(
    .w        (W),
    .n_digits (ND),
    .n_req    (NR),
    .div_w    (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .refresh_div (refresh_div),
    .req         (req),
    .num_in      (num_in),
    .dots_in     (dots_in),
    .gnt         (gnt),
    .en          (en),
    .num         (num),
    .dots        (dots)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: prescaler count, scan position, owner (-1 = idle),
  // last owner, and the previous cycle's owner and inputs for display latency.
  int               m_cnt, m_scan, m_owner, m_last, p_owner;
  logic [NR*W-1:0]  p_num;
  logic [NR*ND-1:0] p_dots;

  function automatic int rr(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_scan = 0; m_owner = -1; m_last = NR - 1; p_owner = -1;
    p_num = '0; p_dots = '0;
  endtask

  task automatic model_step();
    bit m_en;
    int prev;
    m_en = (m_cnt == int'(refresh_div));
    prev = m_owner;
    if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = rr(req, m_last); m_last = m_owner; m_scan = 0;
      end else if (m_en) begin
        m_scan = (m_scan + 1) % ND;
      end
    end else begin
      if (m_en && m_scan == ND - 1) begin
        if (req != 0) begin
          m_owner = rr(req, m_last); m_last = m_owner;
        end else begin
          m_owner = -1;
        end
      end
      if (m_en) m_scan = (m_scan + 1) % ND;
    end
    m_cnt = (m_cnt >= int'(refresh_div)) ? 0 : m_cnt + 1;
    p_owner = prev;
    p_num = num_in;
    p_dots = dots_in;
  endtask

  task automatic check_outputs();
    logic [NR-1:0] e_gnt;
    logic [W-1:0]  e_num;
    logic [ND-1:0] e_dots;
    e_gnt = '0; e_num = '0; e_dots = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    if (m_owner >= 0 && p_owner >= 0) begin
      e_num  = p_num[p_owner*W +: W];
      e_dots = p_dots[p_owner*ND +: ND];
`ifdef SEVEN_SEGMENT_ARBITER_OWNER_DOT_EN
      e_dots[p_owner] = 1'b1;
`endif
    end
    check("m_en",   en,   (m_cnt == int'(refresh_div)) ? 1 : 0);
    check("m_gnt",  gnt,  e_gnt);
    check("m_num",  num,  e_num);
    check("m_dots", dots, e_dots);
  endtask

  // One clock cycle: check on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  int en_cnt, last_change, n_changes, interval_bad;
  logic [NR-1:0] prev_gnt;

  initial begin
    refresh_div = 16'd3; req = '0; num_in = '0; dots_in = '0;
    model_reset();
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_en", en, 0);
    check("rst_num", num, 0);
    check("rst_dots", dots, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); model_step(); #1;

    // Prescaler at refresh_div=3: three strobes in any 12 consecutive cycles.
    en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); en_cnt += int'(en);
      check_outputs();
      @(posedge clk); model_step(); #1;
    end
    check("div3_en_count", en_cnt, 3);

    // refresh_div=0: continuous strobe.
    refresh_div = 16'd0;
    step();
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); en_cnt += int'(en);
      check_outputs();
      @(posedge clk); model_step(); #1;
    end
    check("div0_en_count", en_cnt, 5);

    // Single requester: grant one cycle later, value the cycle after.
    req = 2'b01; num_in[31:0] = 32'h1234_5678;
    step();
    check("single_gnt", gnt, 2'b01);
    step();
    check("single_num", num, 32'h1234_5678);
    for (int i = 0; i < 10; i++) step();

    // Contention: grant alternates every 8 cycles once settled.
    req = 2'b11; num_in = {32'hAAAA_0001, 32'h5555_0000}; dots_in = '0;
    prev_gnt = gnt; last_change = -1; n_changes = 0; interval_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt != prev_gnt) begin
        if (last_change >= 0 && i - last_change != 8) interval_bad++;
        last_change = i; n_changes++;
      end
      prev_gnt = gnt;
    end
    check("contend_interval", interval_bad, 0);
    check("contend_changes_ge4", (n_changes >= 4) ? 1 : 0, 1);

    // Early drop: back to idle, then owner 0 drops req after 3 strobes.
    req = 2'b00;
    for (int i = 0; i < 10; i++) step();
    check("idle_gnt", gnt, 0);
    req = 2'b01;
    step();
    check("drop_grant", gnt, 2'b01);
    for (int i = 0; i < 3; i++) step();
    req = 2'b00;
    for (int i = 0; i < 4; i++) step();
    check("drop_hold", gnt, 2'b01);
    step();
    check("drop_idle_gnt", gnt, 0);
    check("drop_idle_num", num, 0);

    // Reset mid-scan: everything drops immediately; requester 0 wins after.
    req = 2'b11;
    for (int i = 0; i < 13; i++) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_en", en, 0);
    check("mid_rst_num", num, 0);
    check("mid_rst_dots", dots, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); model_step(); #1;
    check("post_rst_gnt", gnt, 2'b01);

    // Randomized run.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) req = NR'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) refresh_div = DW'($urandom_range(0, 3));
      num_in  = {$urandom, $urandom};
      dots_in = NR*ND'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
